// File: rtl/dot_matrix_scan_ctrl_if.sv
// rtl/dot_matrix_scan_ctrl_if.sv - pattern-source and display-side signals of the dot-matrix scan controller
//
// Purpose: bundles every non-clock/reset signal of dot_matrix_scan_ctrl.
// Ports (seen from the slave / scan controller):
//   en          in   scan enable; low freezes scanning and blanks columns
//   wr_en       in   write strobe into the back bank
//   wr_row      in   4-bit row index to write
//   wr_data     in   16-bit row pattern, bit 15 = leftmost column
//   swap_req    in   one-cycle front/back swap request
//   row_bin     out  4-bit row being scanned
//   col         out  16-bit active-high column drive
//   frame_start out  pulse on the first cycle of row 0
//   swap_ack    out  pulse on the cycle a swap takes effect
//   front_bank  out  bank currently displayed
interface dot_matrix_scan_ctrl_if;
  logic        en;
  logic        wr_en;
  logic [3:0]  wr_row;
  logic [15:0] wr_data;
  logic        swap_req;
  logic [3:0]  row_bin;
  logic [15:0] col;
  logic        frame_start;
  logic        swap_ack;
  logic        front_bank;

  modport master (
    output en, wr_en, wr_row, wr_data, swap_req,
    input  row_bin, col, frame_start, swap_ack, front_bank
  );

  modport slave (
    input  en, wr_en, wr_row, wr_data, swap_req,
    output row_bin, col, frame_start, swap_ack, front_bank
  );
endinterface

// File: rtl/dot_matrix_scan_ctrl.sv
// rtl/dot_matrix_scan_ctrl.sv - double-buffered 16x16 dot-matrix row scan controller
//
// Purpose: holds two 16-row frame banks, scans rows with a blanking gap before
// each lit period, and swaps front/back banks only at frame boundaries.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   bus  dot_matrix_scan_ctrl_if.slave (see interface file for signal list)
// Parameters:
//   DWELL  cycles per row with columns lit (>=1)
//   BLANK  cycles per row with columns off, preceding the lit period (>=1)
module dot_matrix_scan_ctrl #(
  parameter int DWELL = 2000,
  parameter int BLANK = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  dot_matrix_scan_ctrl_if.slave bus
);

  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t      state, state_d;
  logic [15:0] ph, ph_d;
  logic [3:0]  row, row_d;
  logic        enter_frame;

  logic [15:0] bank [2][16];
  logic        front;
  logic        pending;
  logic        en_q;
  logic        fs_q;
  logic        ack_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BLANK;
      ph    <= '0;
      row   <= '0;
    end else begin
      state <= state_d;
      ph    <= ph_d;
      row   <= row_d;
    end
  end

  // enter_frame marks the edge that moves from the last lit cycle of row 15
  // into the first blank cycle of row 0; swaps land only on this edge.
  always_comb begin
    state_d     = state;
    ph_d        = ph;
    row_d       = row;
    enter_frame = 1'b0;
    if (bus.en) begin
      if (state == ST_BLANK) begin
        if (ph == BLANK_LAST) begin
          state_d = ST_SHOW;
          ph_d    = '0;
        end else begin
          ph_d = ph + 16'd1;
        end
      end else begin
        if (ph == DWELL_LAST) begin
          state_d     = ST_BLANK;
          ph_d        = '0;
          row_d       = row + 4'd1;
          enter_frame = (row == 4'd15);
        end else begin
          ph_d = ph + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 16; r++) begin
          bank[b][r] <= '0;
        end
      end
      front   <= 1'b0;
      pending <= 1'b0;
      en_q    <= bus.en;
      fs_q    <= bus.en;
      ack_q   <= 1'b0;
    end else begin
      en_q  <= bus.en;
      fs_q  <= enter_frame;
      ack_q <= 1'b0;
      // Indexed by the pre-swap front, so a write on the swap edge lands in
      // the bank that is about to be displayed.
      if (bus.wr_en) begin
        bank[~front][bus.wr_row] <= bus.wr_data;
      end
      if (enter_frame && (pending || bus.swap_req)) begin
        front   <= ~front;
        pending <= 1'b0;
        ack_q   <= 1'b1;
      end else if (bus.swap_req) begin
        pending <= 1'b1;
      end
    end
  end

  // en_q blanks the columns for every cycle whose scan counters were frozen.
  assign bus.row_bin     = row;
  assign bus.col         = (state == ST_SHOW && en_q) ? bank[front][row] : '0;
  assign bus.frame_start = fs_q;
  assign bus.swap_ack    = ack_q;
  assign bus.front_bank  = front;

endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// tb/tb_dot_matrix_scan_ctrl.sv - self-checking bench for dot_matrix_scan_ctrl
module tb_dot_matrix_scan_ctrl;

  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int ROWP  = DW + BL;
  localparam int FRAME = 16 * ROWP;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;

  dot_matrix_scan_ctrl_if bus ();

  dot_matrix_scan_ctrl #(.DWELL(DW), .BLANK(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame position counted in enabled cycles, banks as plain arrays.
  logic [15:0] mbank [2][16];
  int          m_t;
  bit          m_front, m_pend, m_fs, m_ack, m_enq;
  int          exp_row;
  logic [15:0] exp_col;

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_front = 0; m_pend = 0; m_ack = 0;
      m_fs = bus.en; m_enq = bus.en;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 16; r++) mbank[b][r] = '0;
    end else begin
      m_enq = bus.en; m_fs = 0; m_ack = 0;
      if (bus.wr_en) mbank[m_front ^ 1'b1][bus.wr_row] = bus.wr_data;
      if (bus.en) begin
        m_t = (m_t + 1) % FRAME;
        if (m_t == 0) begin
          m_fs = 1;
          if (m_pend || bus.swap_req) begin
            m_front = m_front ^ 1'b1; m_pend = 0; m_ack = 1;
          end
        end else begin
          m_pend = m_pend | bus.swap_req;
        end
      end else begin
        m_pend = m_pend | bus.swap_req;
      end
    end
    #1;
    exp_row = m_t / ROWP;
    exp_col = (m_enq && (m_t % ROWP) >= BL) ? mbank[m_front][exp_row[3:0]] : 16'h0;
    if (chk_on) begin
      check("row_bin", 16'(bus.row_bin), 16'(exp_row));
      check("col", bus.col, exp_col);
      check("frame_start", 16'(bus.frame_start), 16'(m_fs));
      check("swap_ack", 16'(bus.swap_ack), 16'(m_ack));
      check("front_bank", 16'(bus.front_bank), 16'(m_front));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_swap();
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
  endtask

  // Advances until frame_start is seen; n is the number of cycles taken.
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 4 * FRAME);
    check("frame_start_seen", 16'(bus.frame_start), 16'h1);
  endtask

  int          n;
  bit          f_old;
  bit          nz;

  initial begin
    rst = 1'b1;
    bus.en = 1'b1; bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0; bus.swap_req = 1'b0;
    step(1);
    chk_on = 1'b1;
    step(2);
    check("rst_row_bin", 16'(bus.row_bin), 16'h0);
    check("rst_col", bus.col, 16'h0);
    check("rst_front", 16'(bus.front_bank), 16'h0);
    check("rst_frame_start", 16'(bus.frame_start), 16'h1);
    check("rst_swap_ack", 16'(bus.swap_ack), 16'h0);
    rst = 1'b0;

    // Preload bank 1, swap, preload bank 0, swap back.
    for (int r = 0; r < 16; r++) begin
      bus.wr_en = 1'b1; bus.wr_row = 4'(r); bus.wr_data = 16'hF000 | 16'(r);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    pulse_swap();
    wait_fs(n);
    check("preload_front1", 16'(bus.front_bank), 16'h1);
    for (int r = 0; r < 16; r++) begin
      bus.wr_en = 1'b1; bus.wr_row = 4'(r);
      bus.wr_data = (r == 0) ? 16'h8001 : (16'h0100 | 16'(r));
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    pulse_swap();
    wait_fs(n);
    check("preload_front0", 16'(bus.front_bank), 16'h0);

    // Row timeline: 2 blank cycles, 4 lit cycles, then row 1.
    check("tl_c0_col", bus.col, 16'h0);
    step(1);
    check("tl_c1_col", bus.col, 16'h0);
    check("tl_c1_row", 16'(bus.row_bin), 16'h0);
    step(1);
    check("tl_c2_col", bus.col, 16'h8001);
    step(3);
    check("tl_c5_col", bus.col, 16'h8001);
    step(1);
    check("tl_c6_row", 16'(bus.row_bin), 16'h1);
    check("tl_c6_col", bus.col, 16'h0);

    // Back-bank write of row 5, then a mid-frame swap request.
    bus.wr_en = 1'b1; bus.wr_row = 4'd5; bus.wr_data = 16'hA5A5;
    @(negedge clk);
    bus.wr_en = 1'b0;
    step(20);
    pulse_swap();
    wait_fs(n);
    check("swap_ack_at_boundary", 16'(bus.swap_ack), 16'h1);
    check("swap_front1", 16'(bus.front_bank), 16'h1);
    step(5 * ROWP + BL);
    check("row5_a5a5", bus.col, 16'hA5A5);
    check("row5_row_bin", 16'(bus.row_bin), 16'h5);

    // Frame period.
    wait_fs(n);
    wait_fs(n);
    check("frame_period", 16'(n), 16'(FRAME));

    // Two requests in one frame collapse into one toggle.
    f_old = bus.front_bank;
    step(10);
    pulse_swap();
    step(20);
    pulse_swap();
    wait_fs(n);
    check("double_req_ack", 16'(bus.swap_ack), 16'h1);
    check("double_req_toggle", 16'(bus.front_bank), 16'(f_old ^ 1'b1));
    wait_fs(n);
    check("double_req_no_2nd_ack", 16'(bus.swap_ack), 16'h0);
    check("double_req_no_2nd_toggle", 16'(bus.front_bank), 16'(f_old ^ 1'b1));

    // Request on the boundary cycle waits for the following boundary.
    f_old = bus.front_bank;
    pulse_swap();
    check("bnd_req_no_toggle", 16'(bus.front_bank), 16'(f_old));
    wait_fs(n);
    check("bnd_req_period", 16'(n + 1), 16'(FRAME));
    check("bnd_req_ack", 16'(bus.swap_ack), 16'h1);
    check("bnd_req_toggle", 16'(bus.front_bank), 16'(f_old ^ 1'b1));

    // en low for 10 cycles during row 7 SHOW.
    step(7 * ROWP + BL + 1);
    check("pre_pause_row", 16'(bus.row_bin), 16'h7);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pause_col", bus.col, 16'h0);
      check("pause_row", 16'(bus.row_bin), 16'h7);
    end
    bus.en = 1'b1;
    wait_fs(n);
    check("stretched_frame", 16'(7 * ROWP + BL + 1 + 10 + n), 16'(FRAME + 10));

    // Reset during row 9 SHOW with a simultaneous write.
    step(9 * ROWP + BL + 1);
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_row = 4'd9; bus.wr_data = 16'hFFFF;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("mid_rst_row", 16'(bus.row_bin), 16'h0);
    check("mid_rst_col", bus.col, 16'h0);
    check("mid_rst_front", 16'(bus.front_bank), 16'h0);
    rst = 1'b0;
    nz = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (bus.col != 16'h0) nz = 1'b1;
    end
    pulse_swap();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (bus.col != 16'h0) nz = 1'b1;
    end
    check("post_rst_swapped", 16'(bus.front_bank), 16'h1);
    check("banks_zero", 16'(nz), 16'h0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
